// File: rtl/uart_char_tx.sv
// Buffers characters from the core's UART stream in a small FIFO and
// serialises them 8N1 onto a registered, idle-high TX line.
module uart_char_tx #(
    parameter int BAUD_DIV   = 868,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    char_in,
    input  logic                          char_valid,
    input  logic                          clr_ovf,
    output logic                          txd,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(BAUD_DIV);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] FULL      = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e          state_q, state_d;
    logic [BW-1:0]   baudCnt_q, baudCnt_d;
    logic [2:0]      bitIdx_q, bitIdx_d;
    logic [7:0]      shift_q, shift_d;
    logic            txd_q, txd_d;
    logic [AW-1:0]   wrPtr_q, rdPtr_q;
    logic [CW-1:0]   count_q;
    logic            ovf_q;
    logic [7:0]      mem [FIFO_DEPTH];

    logic            pop;
    logic            push;
    logic            drop;
    logic            baudLast;
    logic            fifoNonEmpty;

    assign fifoNonEmpty = (count_q != '0);
    assign baudLast     = (baudCnt_q == BAUD_LAST);
    // A full FIFO still accepts a character when the head leaves at the same edge.
    assign push         = char_valid && ((count_q != FULL) || pop);
    assign drop         = char_valid && !push;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            baudCnt_q <= '0;
            bitIdx_q  <= '0;
            shift_q   <= '0;
            txd_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            baudCnt_q <= baudCnt_d;
            bitIdx_q  <= bitIdx_d;
            shift_q   <= shift_d;
            txd_q     <= txd_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        baudCnt_d = baudCnt_q + 1'b1;
        bitIdx_d  = bitIdx_q;
        shift_d   = shift_q;
        pop       = 1'b0;
        case (state_q)
            IDLE: begin
                baudCnt_d = '0;
                if (fifoNonEmpty) begin
                    pop     = 1'b1;
                    shift_d = mem[rdPtr_q];
                    state_d = START;
                end
            end
            START: begin
                if (baudLast) begin
                    baudCnt_d = '0;
                    bitIdx_d  = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (baudLast) begin
                    baudCnt_d = '0;
                    bitIdx_d  = bitIdx_q + 1'b1;
                    if (bitIdx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (baudLast) begin
                    baudCnt_d = '0;
                    // Chain straight into the next start bit so back-to-back frames have no gap.
                    if (fifoNonEmpty) begin
                        pop     = 1'b1;
                        shift_d = mem[rdPtr_q];
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The line level is decoded from next-state values so txd changes on the same edge as the state.
    always_comb begin
        txd_d = 1'b1;
        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[bitIdx_d];
            default: txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (push) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (drop) begin
                ovf_q <= 1'b1;
            end else if (clr_ovf) begin
                ovf_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtr_q] <= char_in;
        end
    end

    assign txd        = txd_q;
    assign busy       = (state_q != IDLE) || fifoNonEmpty;
    assign fifo_count = count_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_uart_char_tx.sv
// Directed bench for uart_char_tx with BAUD_DIV=4, FIFO_DEPTH=16: single frame,
// gapless burst, overflow and flag priority, and reset in the middle of a frame.
module tb_uart_char_tx;

    localparam int BAUD_DIV   = 4;
    localparam int FIFO_DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] char_in = 8'h00;
    logic       char_valid = 1'b0;
    logic       clr_ovf = 1'b0;
    logic       txd;
    logic       busy;
    logic [4:0] fifo_count;
    logic       overflow;

    int assertCount = 0;
    int failCount   = 0;

    uart_char_tx #(
        .BAUD_DIV   (BAUD_DIV),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .char_in    (char_in),
        .char_valid (char_valid),
        .clr_ovf    (clr_ovf),
        .txd        (txd),
        .busy       (busy),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [7:0] ch, input logic clr);
        char_valid = valid;
        char_in    = ch;
        clr_ovf    = clr;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Walks one 40-cycle frame from cycle offset firstCycle, checking the line level each cycle.
    task automatic checkFrame(input logic [7:0] data, input int firstCycle, input string tag);
        int   b;
        logic expLevel;
        for (int k = firstCycle; k < 10 * BAUD_DIV; k++) begin
            b = k / BAUD_DIV;
            if (b == 0) begin
                expLevel = 1'b0;
            end else if (b == 9) begin
                expLevel = 1'b1;
            end else begin
                expLevel = data[3'(b - 1)];
            end
            checkOutput({tag, " txd"}, 32'(txd), 32'(expLevel));
            checkOutput({tag, " busy"}, 32'(busy), 32'd1);
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit expired before end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #1 rst = 1'b1;
        #2;
        $display("[TB] reset state");
        checkOutput("reset txd", 32'(txd), 32'd1);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset count", 32'(fifo_count), 32'd0);
        checkOutput("reset ovf", 32'(overflow), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        $display("[TB] single character 0x55");
        applyStimulus(1'b1, 8'h55, 1'b0);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("single queued count", 32'(fifo_count), 32'd1);
        checkOutput("single queued txd", 32'(txd), 32'd1);
        checkOutput("single queued busy", 32'(busy), 32'd1);
        tick();
        checkOutput("single pop count", 32'(fifo_count), 32'd0);
        checkFrame(8'h55, 0, "single");
        checkOutput("single done busy", 32'(busy), 32'd0);
        checkOutput("single done txd", 32'(txd), 32'd1);

        $display("[TB] burst 0x41 0x42 0x43");
        applyStimulus(1'b1, 8'h41, 1'b0);
        tick();
        checkOutput("burst E count", 32'(fifo_count), 32'd1);
        applyStimulus(1'b1, 8'h42, 1'b0);
        tick();
        checkOutput("burst E+1 count", 32'(fifo_count), 32'd1);
        applyStimulus(1'b1, 8'h43, 1'b0);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("burst peak count", 32'(fifo_count), 32'd2);
        checkFrame(8'h41, 1, "burst f1");
        checkOutput("burst f2 count", 32'(fifo_count), 32'd1);
        checkFrame(8'h42, 0, "burst f2");
        checkOutput("burst f3 count", 32'(fifo_count), 32'd0);
        checkFrame(8'h43, 0, "burst f3");
        checkOutput("burst done busy", 32'(busy), 32'd0);

        $display("[TB] overflow with 18 pushes");
        for (int i = 0; i < 18; i++) begin
            applyStimulus(1'b1, 8'(8'h10 + i), 1'b0);
            tick();
            if (i == 1) begin
                checkOutput("ovf pop count", 32'(fifo_count), 32'd1);
                checkOutput("ovf pop txd", 32'(txd), 32'd0);
            end
            if (i == 16) begin
                checkOutput("ovf full count", 32'(fifo_count), 32'd16);
                checkOutput("ovf full flag", 32'(overflow), 32'd0);
            end
            if (i == 17) begin
                checkOutput("ovf drop count", 32'(fifo_count), 32'd16);
                checkOutput("ovf drop flag", 32'(overflow), 32'd1);
            end
        end
        applyStimulus(1'b1, 8'hEE, 1'b1);
        tick();
        checkOutput("ovf set-wins flag", 32'(overflow), 32'd1);
        checkOutput("ovf set-wins count", 32'(fifo_count), 32'd16);
        applyStimulus(1'b0, 8'h00, 1'b1);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("ovf cleared flag", 32'(overflow), 32'd0);
        checkFrame(8'h10, 18, "ovf f0");
        for (int i = 1; i < 17; i++) begin
            checkOutput("ovf queue count", 32'(fifo_count), 32'(16 - i));
            checkFrame(8'(8'h10 + i), 0, "ovf frame");
        end
        checkOutput("ovf done busy", 32'(busy), 32'd0);
        checkOutput("ovf done count", 32'(fifo_count), 32'd0);
        checkOutput("ovf done txd", 32'(txd), 32'd1);

        $display("[TB] reset during data bit 3");
        applyStimulus(1'b1, 8'hC3, 1'b0);
        tick();
        applyStimulus(1'b1, 8'h99, 1'b0);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 17; i++) begin
            tick();
        end
        checkOutput("mid bit3 txd", 32'(txd), 32'd0);
        checkOutput("mid bit3 count", 32'(fifo_count), 32'd1);
        #1 rst = 1'b1;
        #1;
        checkOutput("mid rst txd", 32'(txd), 32'd1);
        checkOutput("mid rst busy", 32'(busy), 32'd0);
        checkOutput("mid rst count", 32'(fifo_count), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        checkOutput("post rst idle txd", 32'(txd), 32'd1);
        checkOutput("post rst idle busy", 32'(busy), 32'd0);
        applyStimulus(1'b1, 8'hA5, 1'b0);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("post rst queued txd", 32'(txd), 32'd1);
        checkOutput("post rst queued count", 32'(fifo_count), 32'd1);
        tick();
        checkFrame(8'hA5, 0, "post rst");
        checkOutput("post rst done busy", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
